// File: rtl/top_level.sv
// ---------------------------------------------------------------------------
// top_level : message encryption engine with an internal 256x8 data memory.
//
// A run starts when req drops low while the engine is idle. The engine fetches
// the pre-length P (core[61]), the tap pattern T (core[62]) and the LFSR seed
// (core[63]). It then produces BLOCK_LEN ciphertext bytes. Each byte is the
// plaintext XORed with the 7-bit LFSR state, and the bytes are written to
// core[OUT_BASE..]. When the block is finished, ack goes high.
//
// Plaintext stream: P leading spaces (0x00), then the 61 message characters
// from core[0..60], then padding spaces.
//
// Ports:
//   clk  - system clock, rising-edge active
//   init - asynchronous active-high reset of the engine (memory is untouched)
//   req  - high holds the engine idle / returns it from DONE, low lets it run
//   ack  - high while the finished block is held (state DONE)
//
// Build option:
//   PARITY_EN - when defined, bit 7 of each ciphertext byte is the even
//               parity of bits [6:0]; when undefined, bit 7 is always 0.
//
// FSM states:
//   state   | meaning
//   IDLE    | waiting for req low
//   LD_PRE  | latch pre-length P, clear byte index
//   LD_TAP  | latch tap pattern T
//   LD_SEED | latch LFSR seed S
//   RD      | form plaintext byte for index i
//   WR      | write ciphertext byte i, step LFSR, advance i
//   DONE    | block complete, ack high until req returns high
// ---------------------------------------------------------------------------

module top_level_dm (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] core [0:255];

  always_ff @(posedge clk) begin
    if (we) core[waddr] <= wdata;
  end

  assign rdata = core[raddr];

endmodule

module top_level #(
  parameter int OUT_BASE  = 64,
  parameter int BLOCK_LEN = 64
) (
  input  logic clk,
  input  logic init,
  input  logic req,
  output logic ack
);

  localparam logic [7:0] ADDR_PRE  = 8'd61;
  localparam logic [7:0] ADDR_TAP  = 8'd62;
  localparam logic [7:0] ADDR_SEED = 8'd63;
  localparam logic [7:0] MSG_LAST  = 8'd60;
  localparam logic [7:0] OUT_ADDR  = 8'(OUT_BASE);
  localparam logic [7:0] LAST_IDX  = 8'(BLOCK_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LD_PRE,
    LD_TAP,
    LD_SEED,
    RD,
    WR,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] idx;
  logic [7:0] pre_len;
  logic [6:0] taps;
  logic [6:0] lfsr;
  logic [6:0] plain;

  logic [7:0] raddr;
  logic [7:0] rdata;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       we;

  logic [7:0] msg_off;
  logic       in_pre;
  logic       in_msg;
  logic [6:0] cipher7;
  logic       par_bit;

  top_level_dm DM (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Offset into the message once the leading spaces are done. The subtraction
  // wraps when idx < P, but in that case in_pre masks the result.
  assign msg_off = idx - pre_len;
  assign in_pre  = (idx < pre_len);
  assign in_msg  = (msg_off <= MSG_LAST);

  assign cipher7 = plain ^ lfsr;

`ifdef PARITY_EN
  assign par_bit = ^cipher7;
`else
  assign par_bit = 1'b0;
`endif

  assign waddr = OUT_ADDR + idx;
  assign wdata = {par_bit, cipher7};

  // ack decodes the registered state directly, so it cannot glitch.
  assign ack = (state == DONE);

  always_ff @(posedge clk or posedge init) begin
    if (init) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    raddr     = 8'd0;
    we        = 1'b0;
    case (state)
      IDLE: begin
        if (!req) state_nxt = LD_PRE;
      end
      LD_PRE: begin
        raddr     = ADDR_PRE;
        state_nxt = LD_TAP;
      end
      LD_TAP: begin
        raddr     = ADDR_TAP;
        state_nxt = LD_SEED;
      end
      LD_SEED: begin
        raddr     = ADDR_SEED;
        state_nxt = RD;
      end
      RD: begin
        raddr     = msg_off;
        state_nxt = WR;
      end
      WR: begin
        we        = 1'b1;
        state_nxt = (idx == LAST_IDX) ? DONE : RD;
      end
      DONE: begin
        if (req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      idx     <= 8'd0;
      pre_len <= 8'd0;
      taps    <= 7'd0;
      lfsr    <= 7'd0;
      plain   <= 7'd0;
    end else begin
      case (state)
        LD_PRE: begin
          pre_len <= rdata;
          idx     <= 8'd0;
        end
        LD_TAP:  taps <= rdata[6:0];
        LD_SEED: lfsr <= rdata[6:0];
        RD: begin
          if (in_pre || !in_msg) plain <= 7'd0;
          else                   plain <= rdata[6:0];
        end
        WR: begin
          lfsr <= {lfsr[5:0], ^(lfsr & taps)};
          idx  <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top_level.sv
module tb_top_level;

  logic clk = 1'b0;
  logic init;
  logic req;
  logic ack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] img     [0:255];
  logic [7:0] exp_blk [0:63];

  top_level dut (
    .clk  (clk),
    .init (init),
    .req  (req),
    .ack  (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plaintext byte i: P spaces, then the 61-char message, then spaces.
  function automatic int plain_byte(input int i, input int p);
    if (i < p) return 0;
    if (i - p <= 60) return int'(img[i - p]);
    return 0;
  endfunction

  function automatic int with_par(input int v7);
`ifdef PARITY_EN
    return v7 | (($countones(v7) & 1) << 7);
`else
    return v7;
`endif
  endfunction

  task automatic build_model();
    int p, t, s, c, ct;
    p = int'(img[61]);
    t = int'(img[62]) & 'h7F;
    s = int'(img[63]) & 'h7F;
    for (int i = 0; i < 64; i++) begin
      c  = plain_byte(i, p);
      ct = (c ^ s) & 'h7F;
      exp_blk[i] = 8'(with_par(ct));
      s = ((s << 1) & 'h7F) | ($countones(s & t) & 1);
    end
  endtask

  task automatic push_mem();
    for (int a = 0; a < 256; a++) dut.DM.core[a] <= img[a];
    @(negedge clk);
  endtask

  task automatic set_cfg(input int p, input int t, input int s);
    img[61] = 8'(p);
    img[62] = 8'(t);
    img[63] = 8'(s);
    for (int a = 64; a < 128; a++) img[a] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_ack(input string tag);
    int edges;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (ack !== 1'b1 && edges < 400);
    check({tag, "_latency"}, edges, 132);
  endtask

  task automatic check_block(input string tag);
    build_model();
    for (int i = 0; i < 64; i++)
      check($sformatf("%s[%0d]", tag, i), dut.DM.core[64 + i], exp_blk[i]);
  endtask

  // Full run from reset: preload with init high, release, drop req.
  task automatic run_cfg(input string tag);
    @(negedge clk);
    init = 1'b1;
    req  = 1'b1;
    push_mem();
    init = 1'b0;
    @(negedge clk);
    req = 1'b0;
    wait_ack(tag);
    check_block(tag);
  endtask

  task automatic rand_msg();
    for (int a = 0; a < 61; a++) img[a] = 8'($urandom_range(0, 'h5F));
  endtask

  initial begin : main
    string msg;
    logic [7:0] t1_exp [0:7];
    t1_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03};
    init = 1'b1;
    req  = 1'b1;
    for (int a = 0; a < 256; a++) img[a] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_idx", dut.idx, 0);

    // Test 1: zero message, P=10, T=0x60, seed=1.
    set_cfg(10, 'h60, 'h01);
    push_mem();
    init = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_hold_ack", ack, 0);
    req = 1'b0;
    wait_ack("t1");
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_lit[%0d]", i), {25'd0, dut.DM.core[64 + i][6:0]}, t1_exp[i]);
    check_block("t1");

    repeat (3) @(negedge clk);
    check("done_hold_ack", ack, 1);
    req = 1'b1;
    @(posedge clk);
    #1;
    check("done_req_ack_fall", ack, 0);

    // Fresh run with a new seed, started from IDLE without reset.
    img[63] = 8'h7F;
    dut.DM.core[63] <= 8'h7F;
    @(negedge clk);
    req = 1'b0;
    wait_ack("t1b");
    check_block("t1b");

    // Test 2: known message.
    msg = "Mr. Watson, come here. I want to see you.";
    for (int a = 0; a < 61; a++) img[a] = 8'h00;
    for (int k = 0; k < msg.len(); k++) img[k] = msg[k] - 8'h20;
    set_cfg(10, 'h60, 'h01);
    run_cfg("t2");
    check("t2_core74", dut.DM.core[74], 8'h35);

    // Test 3: seed 0 passes plaintext through.
    rand_msg();
    set_cfg(15, $urandom_range(0, 255), 'h00);
    run_cfg("t3");
    for (int i = 0; i < 64; i++)
      check($sformatf("t3_plain[%0d]", i), dut.DM.core[64 + i], with_par(plain_byte(i, 15)));

    // Test 4: init mid-run, then rerun with req already low.
    rand_msg();
    set_cfg(7, 'h5A, 'h33);
    @(negedge clk);
    init = 1'b1;
    req  = 1'b1;
    push_mem();
    init = 1'b0;
    @(negedge clk);
    req = 1'b0;
    repeat (50) @(posedge clk);
    #3;
    init = 1'b1;
    #1;
    check("midrun_ack", ack, 0);
    check("midrun_idx", dut.idx, 0);
    for (int a = 64; a < 128; a++) img[a] = 8'($urandom_range(0, 255));
    push_mem();
    init = 1'b0;
    wait_ack("t4");
    check_block("t4");

    // Async reset while in DONE drops ack without a clock edge.
    @(posedge clk);
    #2;
    init = 1'b1;
    #1;
    check("done_init_ack", ack, 0);
    @(negedge clk);
    req  = 1'b1;
    init = 1'b0;

    // Boundaries: P=0 (tail past message is space), P=3 (last byte is core[60]).
    rand_msg();
    set_cfg(0, 'h71, 'h55);
    run_cfg("p0");
    rand_msg();
    set_cfg(3, 'h44, 'h2B);
    run_cfg("p3");

    // Randomized configurations, including P beyond the block length.
    for (int r = 0; r < 4; r++) begin
      rand_msg();
      set_cfg($urandom_range(0, 80), $urandom_range(0, 255), $urandom_range(0, 255));
      run_cfg($sformatf("rnd%0d", r));
    end
    rand_msg();
    set_cfg(200, $urandom_range(0, 255), $urandom_range(1, 255));
    run_cfg("pbig");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
